// File: rtl/snn_image_loader.sv
// snn_image_loader
//   Front end of the SNN inference core. Receives a 1-bit image as packed
//   bytes from the UART, unpacks it one pixel per cycle into an internal image
//   RAM, pulses start to the core, then serves the core's pixel reads while
//   holding off new frames until the core reports done.
//
// Configuration macro:
//   SNN_LOADER_TIMEOUT_EN  when defined, a partial frame is discarded if no new
//                          byte arrives within TIMEOUT_CYC cycles (overrun set).
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   rx_rdy, rx_data   one-cycle byte strobe and byte from the UART
//                     (bit j of byte k is pixel 8k+j)
//   addr_input_unit   pixel read address from the core
//   q_input           registered pixel read data (1 cycle latency, 0 out of range)
//   core_done         one-cycle pulse: inference complete
//   start             one-cycle pulse: full image stored
//   busy              high from the final byte's unpack until core_done
//   overrun           sticky dropped-byte flag, cleared by a new frame's first byte
//   dbg_state         current FSM state (RX=0, UNPACK=1, START=2, WAIT_CORE=3)
//
// Handshake: rx_rdy is a valid strobe with no ready back-pressure. A byte is
//   taken only when it arrives in RX; in any other state it is discarded and
//   overrun is raised.
module snn_image_loader #(
  parameter int unsigned PIXELS      = 784,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  input  logic [ADDR_W-1:0] addr_input_unit,
  output logic              q_input,
  input  logic              core_done,
  output logic              start,
  output logic              busy,
  output logic              overrun,
  output logic [1:0]        dbg_state
);

  localparam int unsigned BYTES = PIXELS / 8;
  localparam int unsigned BC_W  = $clog2(BYTES + 1);

  typedef enum logic [1:0] {
    ST_RX        = 2'd0,
    ST_UNPACK    = 2'd1,
    ST_START     = 2'd2,
    ST_WAIT_CORE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              overrun_q, overrun_d;
  logic              q_q;
  logic              ram_we;
  logic [ADDR_W-1:0] wr_addr;
  logic              last_byte;

  logic mem [PIXELS];

`ifdef SNN_LOADER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

  assign last_byte = (byte_cnt_q == BC_W'(BYTES - 1));
  // byte_cnt never exceeds BYTES-1 while unpacking, so this stays below PIXELS.
  assign wr_addr   = (ADDR_W'(byte_cnt_q) << 3) | ADDR_W'(bit_cnt_q);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    overrun_d  = overrun_q;
    ram_we     = 1'b0;
`ifdef SNN_LOADER_TIMEOUT_EN
    tmo_d      = '0;
`endif
    case (state_q)
      ST_RX: begin
        if (rx_rdy) begin
          shreg_d   = rx_data;
          bit_cnt_d = 3'd0;
          state_d   = ST_UNPACK;
          if (byte_cnt_q == '0) overrun_d = 1'b0;
        end
`ifdef SNN_LOADER_TIMEOUT_EN
        // Idle time between bytes of a started frame; a stall abandons it.
        else if (byte_cnt_q != '0) begin
          if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            byte_cnt_d = '0;
            overrun_d  = 1'b1;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
`endif
      end
      ST_UNPACK: begin
        ram_we    = 1'b1;
        shreg_d   = shreg_q >> 1;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (last_byte) begin
            byte_cnt_d = '0;
            state_d    = ST_START;
          end else begin
            byte_cnt_d = byte_cnt_q + BC_W'(1);
            state_d    = ST_RX;
          end
        end
        if (rx_rdy) overrun_d = 1'b1;
      end
      ST_START: begin
        state_d = ST_WAIT_CORE;
        if (rx_rdy) overrun_d = 1'b1;
      end
      ST_WAIT_CORE: begin
        if (core_done) state_d = ST_RX;
        // A byte coinciding with core_done is still dropped.
        if (rx_rdy) overrun_d = 1'b1;
      end
      default: state_d = ST_RX;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RX;
      byte_cnt_q <= '0;
      bit_cnt_q  <= 3'd0;
      shreg_q    <= 8'd0;
      overrun_q  <= 1'b0;
`ifdef SNN_LOADER_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      overrun_q  <= overrun_d;
`ifdef SNN_LOADER_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  // Image RAM is deliberately not reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem[wr_addr] <= shreg_q[0];
  end

  // One-cycle read latency lines pixels up with the weight ROM at the MAC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else if (32'(addr_input_unit) < PIXELS) begin
      q_q <= mem[addr_input_unit];
    end else begin
      q_q <= 1'b0;
    end
  end

  assign q_input   = q_q;
  assign start     = (state_q == ST_START);
  assign busy      = (state_q == ST_START) || (state_q == ST_WAIT_CORE) ||
                     ((state_q == ST_UNPACK) && last_byte);
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_snn_image_loader.sv
module tb_snn_image_loader;
  localparam int PIXELS = 784;
  localparam int ADDR_W = 10;
  localparam int BYTES  = 98;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx_rdy = 1'b0;
  logic [7:0]        rx_data = 8'd0;
  logic [ADDR_W-1:0] addr_input_unit = '0;
  logic              core_done = 1'b0;
  logic              q_input, start, busy, overrun;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  logic [0:0] exp_q[$];
  int         exp_addr_q[$];
  int         addr_list[$];
  logic [7:0] frame[BYTES];
  logic [7:0] img_model[BYTES];

  snn_image_loader #(
    .PIXELS(PIXELS), .ADDR_W(ADDR_W), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .addr_input_unit(addr_input_unit), .q_input(q_input),
    .core_done(core_done), .start(start), .busy(busy),
    .overrun(overrun), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk) if (start === 1'b1) start_cnt++;

  // reference model: pixel p lives in bit p%8 of byte p/8
  function automatic logic model_pixel(int a);
    logic [7:0] b;
    if (a >= PIXELS) return 1'b0;
    b = img_model[a / 8];
    return b[a % 8];
  endfunction

  // driver tasks (all leave time at posedge+1)
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    tick(1);
    rx_rdy  = 1'b0;
  endtask

  task automatic send_bytes(int first, int last, int gap);
    for (int i = first; i <= last; i++) begin
      send_byte(frame[i]);
      tick(gap);
    end
  endtask

  task automatic pulse_done();
    core_done = 1'b1;
    tick(1);
    core_done = 1'b0;
  endtask

  task automatic randomize_frame();
    for (int i = 0; i < BYTES; i++) frame[i] = 8'($urandom);
  endtask

  task automatic commit_frame();
    for (int i = 0; i < BYTES; i++) img_model[i] = frame[i];
  endtask

  task automatic add_random_reads(int n);
    for (int i = 0; i < n; i++) addr_list.push_back(int'($urandom_range(0, PIXELS + 60)));
  endtask

  // scoreboard: one address per cycle, result checked one cycle later
  task automatic run_reads(string tag);
    int n;
    int a;
    logic e;
    n = addr_list.size();
    exp_q.delete();
    exp_addr_q.delete();
    @(negedge clk);
    for (int i = 0; i <= n; i++) begin
      if (i > 0) begin
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        a = exp_addr_q.pop_front();
        checks++;
        if (q_input !== e) begin
          errors++;
          $display("FAIL %s read addr %0d: q_input=%b expected %b", tag, a, q_input, e);
        end
      end
      if (i < n) begin
        addr_input_unit = ADDR_W'(addr_list[i]);
        exp_q.push_back(model_pixel(addr_list[i]));
        exp_addr_q.push_back(addr_list[i]);
      end
    end
    addr_list.delete();
    tick(1);
  endtask

  // final byte of a frame with exact start timing; optionally pulses
  // core_done in the START cycle, where it must be ignored
  task automatic send_last_checked(logic [7:0] b, bit done_in_start, string tag);
    send_byte(b);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_final_unpack: busy=%b expected 1", tag, busy); end
    repeat (7) @(posedge clk);
    @(negedge clk);
    checks++;
    if (start !== 1'b0) begin errors++; $display("FAIL %s start_early: start=%b expected 0", tag, start); end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (start !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s start_pulse: start=%b busy=%b expected 1 1", tag, start, busy);
    end
    if (done_in_start) core_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    core_done = 1'b0;
    checks++;
    if (start !== 1'b0 || busy !== 1'b1 || dbg_state !== 2'd3) begin
      errors++;
      $display("FAIL %s after_start: start=%b busy=%b state=%0d expected 0 1 3", tag, start, busy, dbg_state);
    end
    tick(1);
  endtask

  task automatic check_idle(string tag);
    checks++;
    if (busy !== 1'b0 || dbg_state !== 2'd0 || start !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: busy=%b state=%0d start=%b expected 0 0 0", tag, busy, dbg_state, start);
    end
  endtask

  // tests
  task automatic test_reset();
    tick(3);
    checks++;
    if ({start, busy, overrun, q_input, dbg_state} !== 6'b0) begin
      errors++;
      $display("FAIL reset_held: start/busy/overrun/q/state=%b expected 000000",
               {start, busy, overrun, q_input, dbg_state});
    end
    rst_n = 1'b1;
    tick(2);
    check_idle("reset_release");
  endtask

  task automatic test_full_frame();
    int s0;
    for (int i = 0; i < BYTES; i++) frame[i] = 8'hA5;
    s0 = start_cnt;
    send_byte(frame[0]);
    checks++;
    if (busy !== 1'b0 || dbg_state !== 2'd1) begin
      errors++;
      $display("FAIL t1_first_unpack: busy=%b state=%0d expected 0 1", busy, dbg_state);
    end
    tick(19);
    send_bytes(1, 96, 20);
    checks++;
    if (start_cnt - s0 !== 0) begin errors++; $display("FAIL t1_no_early_start: starts=%0d expected 0", start_cnt - s0); end
    send_last_checked(frame[97], 1'b0, "t1");
    checks++;
    if (start_cnt - s0 !== 1) begin errors++; $display("FAIL t1_start_count: starts=%0d expected 1", start_cnt - s0); end
    commit_frame();
    addr_list.push_back(0); addr_list.push_back(1);
    addr_list.push_back(2); addr_list.push_back(783);
    add_random_reads(16);
    run_reads("t1");
    pulse_done();
    tick(1);
    check_idle("t1_done");
  endtask

  task automatic test_pixel_order();
    int s0;
    for (int i = 0; i < BYTES; i++) frame[i] = 8'h00;
    frame[0]  = 8'h01;
    frame[97] = 8'h80;
    s0 = start_cnt;
    send_bytes(0, 96, 12);
    send_last_checked(frame[97], 1'b1, "t2");
    checks++;
    if (start_cnt - s0 !== 1) begin errors++; $display("FAIL t2_start_count: starts=%0d expected 1", start_cnt - s0); end
    commit_frame();
    addr_list.push_back(0);   addr_list.push_back(783); addr_list.push_back(900);
    addr_list.push_back(1);   addr_list.push_back(7);   addr_list.push_back(776);
    addr_list.push_back(782); addr_list.push_back(784); addr_list.push_back(1023);
    add_random_reads(10);
    run_reads("t2");
    pulse_done();
    tick(1);
    check_idle("t2_done");
  endtask

  task automatic test_busy_lockout();
    int s0;
    randomize_frame();
    send_bytes(0, 96, 12);
    send_last_checked(frame[97], 1'b0, "t3a");
    commit_frame();
    send_byte(8'hFF);
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL t3_drop_wait: overrun=%b busy=%b expected 1 1", overrun, busy);
    end
    tick(3);
    add_random_reads(20);
    run_reads("t3_unchanged");
    // byte together with core_done: dropped, FSM returns to RX
    rx_data = 8'h3C; rx_rdy = 1'b1; core_done = 1'b1;
    tick(1);
    rx_rdy = 1'b0; core_done = 1'b0;
    checks++;
    if (overrun !== 1'b1 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL t3_simultaneous: overrun=%b state=%0d expected 1 0", overrun, dbg_state);
    end
    tick(2);
    randomize_frame();
    s0 = start_cnt;
    send_byte(frame[0]);
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL t3_overrun_clear: overrun=%b expected 0", overrun); end
    tick(12);
    send_bytes(1, 96, 12);
    send_last_checked(frame[97], 1'b0, "t3b");
    checks++;
    if (start_cnt - s0 !== 1) begin errors++; $display("FAIL t3_start_count: starts=%0d expected 1", start_cnt - s0); end
    commit_frame();
    add_random_reads(20);
    run_reads("t3b");
    pulse_done();
  endtask

  task automatic test_back_to_back();
    int s0;
    randomize_frame();
    s0 = start_cnt;
    send_byte(frame[0]);
    tick(2);
    send_byte(8'hFF);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL t4_drop_unpack: overrun=%b expected 1", overrun); end
    tick(12);
    send_bytes(1, 96, 12);
    checks++;
    if (start_cnt - s0 !== 0) begin errors++; $display("FAIL t4_no_early_start: starts=%0d expected 0", start_cnt - s0); end
    send_last_checked(frame[97], 1'b0, "t4");
    checks++;
    if (start_cnt - s0 !== 1) begin errors++; $display("FAIL t4_start_count: starts=%0d expected 1", start_cnt - s0); end
    commit_frame();
    addr_list.push_back(0); addr_list.push_back(5); addr_list.push_back(8);
    add_random_reads(20);
    run_reads("t4");
    pulse_done();
  endtask

  task automatic test_reset_mid_frame();
    int s0;
    randomize_frame();
    s0 = start_cnt;
    send_bytes(0, 49, 12);
    rst_n = 1'b0;
    tick(2);
    checks++;
    if ({start, busy, overrun, q_input, dbg_state} !== 6'b0) begin
      errors++;
      $display("FAIL t5_reset_outputs: start/busy/overrun/q/state=%b expected 000000",
               {start, busy, overrun, q_input, dbg_state});
    end
    rst_n = 1'b1;
    tick(2);
    randomize_frame();
    send_bytes(0, 96, 12);
    send_last_checked(frame[97], 1'b0, "t5");
    checks++;
    if (start_cnt - s0 !== 1) begin errors++; $display("FAIL t5_start_count: starts=%0d expected 1", start_cnt - s0); end
    commit_frame();
    add_random_reads(30);
    run_reads("t5");
    pulse_done();
  endtask

  task automatic test_timeout();
    int s0;
    randomize_frame();
    s0 = start_cnt;
    send_bytes(0, 9, 12);
    tick(150);
`ifdef SNN_LOADER_TIMEOUT_EN
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL t6_timeout_overrun: overrun=%b expected 1", overrun); end
    randomize_frame();
    send_bytes(0, 96, 12);
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL t6_overrun_clear: overrun=%b expected 0", overrun); end
`else
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL t6_no_timeout: overrun=%b expected 0", overrun); end
    send_bytes(10, 96, 12);
`endif
    send_last_checked(frame[97], 1'b0, "t6");
    checks++;
    if (start_cnt - s0 !== 1) begin errors++; $display("FAIL t6_start_count: starts=%0d expected 1", start_cnt - s0); end
    commit_frame();
    add_random_reads(30);
    run_reads("t6");
    pulse_done();
    tick(1);
    check_idle("t6_done");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_pixel_order();
    test_busy_lockout();
    test_back_to_back();
    test_reset_mid_frame();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
